alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if -- bundle of the ALU sequencer request/control signals.
//   start, opcode          : instruction request (driven by master)
//   rb_out .. hi_in        : datapath bus gates and register loads
//   add .. not_op          : one-hot ALU operation strobes
//   busy, done, illegal    : sequencer status
// Modports: master (requester side), slave (sequencer side).
interface alu_sequencer_if;
  logic       start;
  logic [4:0] opcode;
  logic       rb_out, rc_out, yin, zin, zlow_out, zhigh_out;
  logic       ra_in, lo_in, hi_in;
  logic       add, sub, mul, div, and_op, or_op, shr, shra, shl, ror, rol, neg, not_op;
  logic       busy, done, illegal;

  modport master (
    output start, opcode,
    input  rb_out, rc_out, yin, zin, zlow_out, zhigh_out, ra_in, lo_in, hi_in,
    input  add, sub, mul, div, and_op, or_op, shr, shra, shl, ror, rol, neg, not_op,
    input  busy, done, illegal
  );

  modport slave (
    input  start, opcode,
    output rb_out, rc_out, yin, zin, zlow_out, zhigh_out, ra_in, lo_in, hi_in,
    output add, sub, mul, div, and_op, or_op, shr, shra, shl, ror, rol, neg, not_op,
    output busy, done, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer -- control-step sequencer for one ALU instruction.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : alu_sequencer_if.slave (start/opcode in; gates, loads, strobes,
//           busy/done/illegal out)
// Parameter EXEC_CYCLES (1-15): cycles spent in EXEC.
// Optional build macro ILLEGAL_TRAP_EN: an illegal opcode parks the
// sequencer in TRAP (busy+illegal) until clear; otherwise illegal pulses
// for one cycle and the sequencer stays idle.
module alu_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input logic           clock,
  input logic           clear,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_T_Y, S_EXEC, S_WB_LO, S_WB_HI
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  // One-hot order: add sub mul div and or shr shra shl ror rol neg not
  function automatic logic [12:0] decode(input logic [4:0] op);
    case (op)
      5'b00011: decode = 13'd1 << 12;
      5'b00100: decode = 13'd1 << 11;
      5'b01111: decode = 13'd1 << 10;
      5'b10000: decode = 13'd1 << 9;
      5'b01010: decode = 13'd1 << 8;
      5'b01011: decode = 13'd1 << 7;
      5'b00101: decode = 13'd1 << 6;
      5'b00110: decode = 13'd1 << 5;
      5'b00111: decode = 13'd1 << 4;
      5'b01000: decode = 13'd1 << 3;
      5'b01001: decode = 13'd1 << 2;
      5'b10001: decode = 13'd1 << 1;
      5'b10010: decode = 13'd1;
      default:  decode = '0;
    endcase
  endfunction

  state_t      state, next_state;
  logic [3:0]  exec_cnt;
  logic [12:0] op_q;      // latched opcode, held in decoded one-hot form
  logic [12:0] in_dec;
  logic        done_q;
  logic        op_md, op_un;
  logic [12:0] strobe;
  logic        rb_out, rc_out, yin, zin, zlow_out, zhigh_out, ra_in, lo_in, hi_in;

  assign in_dec = decode(bus.opcode);
  assign op_md  = op_q[10] | op_q[9];
  assign op_un  = op_q[1]  | op_q[0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    strobe     = '0;
    rb_out     = 1'b0;
    rc_out     = 1'b0;
    yin        = 1'b0;
    zin        = 1'b0;
    zlow_out   = 1'b0;
    zhigh_out  = 1'b0;
    ra_in      = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (in_dec == '0) begin
`ifdef ILLEGAL_TRAP_EN
            next_state = S_TRAP;
`else
            next_state = S_IDLE;
`endif
          end else if (in_dec[1] | in_dec[0]) begin
            next_state = S_EXEC;
          end else begin
            next_state = S_T_Y;
          end
        end
      end
      S_T_Y: begin
        rb_out     = 1'b1;
        yin        = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        zin    = 1'b1;
        strobe = op_q;
        if (op_un) rb_out = 1'b1;
        else       rc_out = 1'b1;
        if (exec_cnt == 4'd0) next_state = S_WB_LO;
      end
      S_WB_LO: begin
        zlow_out = 1'b1;
        if (op_md) begin
          lo_in      = 1'b1;
          next_state = S_WB_HI;
        end else begin
          ra_in      = 1'b1;
          next_state = S_IDLE;
        end
      end
      S_WB_HI: begin
        zhigh_out  = 1'b1;
        hi_in      = 1'b1;
        next_state = S_IDLE;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: next_state = S_TRAP;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Counter is loaded with EXEC_CYCLES-1 on entry and counts down to zero,
  // holding there; EXEC exits when it reads zero.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      exec_cnt <= '0;
      op_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      if (state != S_EXEC && next_state == S_EXEC)
        exec_cnt <= 4'(EXEC_CYCLES - 1);
      else if (state == S_EXEC && exec_cnt != 4'd0)
        exec_cnt <= exec_cnt - 4'd1;
      if (state == S_IDLE && bus.start)
        op_q <= in_dec;
      done_q <= (state == S_WB_LO && !op_md) || (state == S_WB_HI);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal = (state == S_TRAP);
`else
  logic illegal_q;
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) illegal_q <= 1'b0;
    else        illegal_q <= (state == S_IDLE) && bus.start && (in_dec == '0);
  end
  assign bus.illegal = illegal_q;
`endif

  assign bus.rb_out    = rb_out;
  assign bus.rc_out    = rc_out;
  assign bus.yin       = yin;
  assign bus.zin       = zin;
  assign bus.zlow_out  = zlow_out;
  assign bus.zhigh_out = zhigh_out;
  assign bus.ra_in     = ra_in;
  assign bus.lo_in     = lo_in;
  assign bus.hi_in     = hi_in;
  assign {bus.add, bus.sub, bus.mul, bus.div, bus.and_op, bus.or_op, bus.shr,
          bus.shra, bus.shl, bus.ror, bus.rol, bus.neg, bus.not_op} = strobe;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer -- scoreboard bench for alu_sequencer. Two instances
// (EXEC_CYCLES 1 and 3) receive identical stimulus; each has its own queue
// of expected per-cycle control vectors, filled when a start is accepted.
module tb_alu_sequencer;

  typedef struct packed {
    logic        rb_out, rc_out, yin, zin, zlow_out, zhigh_out, ra_in, lo_in, hi_in;
    logic [12:0] op;  // add sub mul div and or shr shra shl ror rol neg not
    logic        busy, done, illegal;
  } ctl_t;

  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_ROL = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010, OP_OR  = 5'b01011, OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010;
  localparam logic [4:0] OP_BAD = 5'b11111;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  alu_sequencer_if ifc1 ();
  alu_sequencer_if ifc3 ();

  alu_sequencer #(.EXEC_CYCLES(1)) dut1 (.clock(clock), .clear(clear), .bus(ifc1.slave));
  alu_sequencer #(.EXEC_CYCLES(3)) dut3 (.clock(clock), .clear(clear), .bus(ifc3.slave));

  ctl_t v1, v3;
  assign v1 = {ifc1.rb_out, ifc1.rc_out, ifc1.yin, ifc1.zin, ifc1.zlow_out, ifc1.zhigh_out,
               ifc1.ra_in, ifc1.lo_in, ifc1.hi_in,
               ifc1.add, ifc1.sub, ifc1.mul, ifc1.div, ifc1.and_op, ifc1.or_op, ifc1.shr,
               ifc1.shra, ifc1.shl, ifc1.ror, ifc1.rol, ifc1.neg, ifc1.not_op,
               ifc1.busy, ifc1.done, ifc1.illegal};
  assign v3 = {ifc3.rb_out, ifc3.rc_out, ifc3.yin, ifc3.zin, ifc3.zlow_out, ifc3.zhigh_out,
               ifc3.ra_in, ifc3.lo_in, ifc3.hi_in,
               ifc3.add, ifc3.sub, ifc3.mul, ifc3.div, ifc3.and_op, ifc3.or_op, ifc3.shr,
               ifc3.shra, ifc3.shl, ifc3.ror, ifc3.rol, ifc3.neg, ifc3.not_op,
               ifc3.busy, ifc3.done, ifc3.illegal};

  ctl_t q1[$];
  ctl_t q3[$];
  bit   trap1 = 1'b0, trap3 = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [12:0] strobe_of(input logic [4:0] op);
    case (op)
      OP_ADD:   return 13'b1000000000000;
      OP_SUB:   return 13'b0100000000000;
      OP_MUL:   return 13'b0010000000000;
      OP_DIV:   return 13'b0001000000000;
      OP_AND:   return 13'b0000100000000;
      OP_OR:    return 13'b0000010000000;
      5'b00101: return 13'b0000001000000;
      5'b00110: return 13'b0000000100000;
      5'b00111: return 13'b0000000010000;
      5'b01000: return 13'b0000000001000;
      OP_ROL:   return 13'b0000000000100;
      OP_NEG:   return 13'b0000000000010;
      OP_NOT:   return 13'b0000000000001;
      default:  return 13'b0;
    endcase
  endfunction

  function automatic bit is_md(input logic [4:0] op);
    return op == OP_MUL || op == OP_DIV;
  endfunction

  function automatic bit is_un(input logic [4:0] op);
    return op == OP_NEG || op == OP_NOT;
  endfunction

  function automatic int seq_len(input logic [4:0] op, input int ec);
    if (strobe_of(op) == 13'b0) begin
`ifdef ILLEGAL_TRAP_EN
      return 0;
`else
      return 1;
`endif
    end
    if (is_un(op)) return ec + 2;
    if (is_md(op)) return ec + 4;
    return ec + 3;
  endfunction

  // Expected vector for cycle k+1 after the accepting edge.
  function automatic ctl_t seq_at(input logic [4:0] op, input int ec, input int k);
    ctl_t c;
    int   e0;
    c  = '0;
    if (strobe_of(op) == 13'b0) begin
      c.illegal = 1'b1;
      return c;
    end
    e0 = is_un(op) ? 0 : 1;
    if (k < e0) begin
      c.rb_out = 1'b1; c.yin = 1'b1; c.busy = 1'b1;
    end else if (k < e0 + ec) begin
      c.zin = 1'b1; c.op = strobe_of(op); c.busy = 1'b1;
      if (is_un(op)) c.rb_out = 1'b1;
      else           c.rc_out = 1'b1;
    end else if (k == e0 + ec) begin
      c.zlow_out = 1'b1; c.busy = 1'b1;
      if (is_md(op)) c.lo_in = 1'b1;
      else           c.ra_in = 1'b1;
    end else if (is_md(op) && k == e0 + ec + 1) begin
      c.zhigh_out = 1'b1; c.hi_in = 1'b1; c.busy = 1'b1;
    end else begin
      c.done = 1'b1;
    end
    return c;
  endfunction

  function automatic ctl_t trap_vec();
    ctl_t c;
    c = '0;
    c.busy = 1'b1;
    c.illegal = 1'b1;
    return c;
  endfunction

  // Called just after a falling edge: drive inputs, update models for an
  // accept at the next rising edge, then check both instances one falling edge later.
  task automatic step(input string tag, input logic s, input logic [4:0] op);
    ctl_t e1, e3;
    ifc1.start = s; ifc1.opcode = op;
    ifc3.start = s; ifc3.opcode = op;
    if (s && q1.size() == 0 && !trap1) begin
      for (int k = 0; k < seq_len(op, 1); k++) q1.push_back(seq_at(op, 1, k));
`ifdef ILLEGAL_TRAP_EN
      if (strobe_of(op) == 13'b0) trap1 = 1'b1;
`endif
    end
    if (s && q3.size() == 0 && !trap3) begin
      for (int k = 0; k < seq_len(op, 3); k++) q3.push_back(seq_at(op, 3, k));
`ifdef ILLEGAL_TRAP_EN
      if (strobe_of(op) == 13'b0) trap3 = 1'b1;
`endif
    end
    @(posedge clock);
    @(negedge clock);
    ifc1.start = 1'b0;
    ifc3.start = 1'b0;
    e1 = (q1.size() != 0) ? q1.pop_front() : (trap1 ? trap_vec() : ctl_t'(0));
    e3 = (q3.size() != 0) ? q3.pop_front() : (trap3 ? trap_vec() : ctl_t'(0));
    check_val({tag, "/ec1"}, 32'(v1), 32'(e1));
    check_val({tag, "/ec3"}, 32'(v3), 32'(e3));
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 40) begin
      step(tag, 1'b0, 5'b0);
      n++;
    end
    if (n >= 40) check_val({tag, "_timeout"}, 32'(q1.size() + q3.size()), 32'd0);
  endtask

  initial begin
    ifc1.start = 1'b0; ifc1.opcode = '0;
    ifc3.start = 1'b0; ifc3.opcode = '0;
    repeat (2) @(negedge clock);
    check_val("reset/ec1", 32'(v1), 32'd0);
    check_val("reset/ec3", 32'(v3), 32'd0);
    clear = 1'b1;

    step("add", 1'b1, OP_ADD);  drain("add");
    step("mul", 1'b1, OP_MUL);  drain("mul");
    step("neg", 1'b1, OP_NEG);  drain("neg");
    step("not", 1'b1, OP_NOT);  drain("not");
    step("div", 1'b1, OP_DIV);  drain("div");

    // start held high: each instance re-accepts in its done cycle
    for (int i = 0; i < 14; i++) step("b2b", 1'b1, OP_OR);
    drain("b2b");

    // start with ROL while SUB is in flight is ignored
    step("sub_busy", 1'b1, OP_SUB);
    for (int i = 0; i < 3; i++) step("rol_ign", 1'b1, OP_ROL);
    drain("sub_busy");

    step("illegal", 1'b1, OP_BAD);
    drain("illegal");
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) step("trap_hold", 1'b1, OP_SUB);
    clear = 1'b0;
    #1;
    check_val("trap_clear/ec1", 32'(v1), 32'd0);
    check_val("trap_clear/ec3", 32'(v3), 32'd0);
    q1.delete(); q3.delete(); trap1 = 1'b0; trap3 = 1'b0;
    @(negedge clock);
    clear = 1'b1;
`endif
    step("sub_after", 1'b1, OP_SUB);
    drain("sub_after");

    // asynchronous clear in the middle of DIV EXEC
    step("div_clr", 1'b1, OP_DIV);
    step("div_clr", 1'b0, 5'b0);
    #2 clear = 1'b0;
    #1;
    check_val("clr_async/ec1", 32'(v1), 32'd0);
    check_val("clr_async/ec3", 32'(v3), 32'd0);
    q1.delete(); q3.delete(); trap1 = 1'b0; trap3 = 1'b0;
    @(negedge clock);
    check_val("clr_hold/ec1", 32'(v1), 32'd0);
    check_val("clr_hold/ec3", 32'(v3), 32'd0);
    clear = 1'b1;
    step("and_post", 1'b1, OP_AND);
    drain("and_post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
